// File: rtl/sprite_scheduler.sv
// sprite_scheduler: per-frame walk of a sprite register table, offering active entries to graphics with animation phase.
module sprite_scheduler #(
  parameter int MAX_SPRITES   = 16,
  parameter int NUM_FRAMES    = 18,
  parameter int CANVAS_WIDTH  = 360,
  parameter int CANVAS_HEIGHT = 720,
  parameter int ANIM_DIV      = 4,
  parameter int MAX_ANIM      = 4
) (
  input  logic                             clk_pixel,
  input  logic                             sys_rst,
  input  logic [5:0]                       frame_count,
  input  logic                             wr_en,
  input  logic [$clog2(MAX_SPRITES)-1:0]   wr_index,
  input  logic                             wr_active,
  input  logic [$clog2(CANVAS_WIDTH)-1:0]  wr_x,
  input  logic [$clog2(CANVAS_HEIGHT)-1:0] wr_y,
  input  logic [$clog2(NUM_FRAMES)-1:0]    wr_frame_base,
  input  logic [2:0]                       wr_anim_len,
  input  logic                             sprite_ready,
  output logic                             sprite_valid,
  output logic [$clog2(CANVAS_WIDTH)-1:0]  sprite_x,
  output logic [$clog2(CANVAS_HEIGHT)-1:0] sprite_y,
  output logic [$clog2(NUM_FRAMES)-1:0]    sprite_frame_number,
  output logic                             scan_busy,
  output logic                             frame_overrun
);
  localparam int IW = $clog2(MAX_SPRITES);
  localparam int XW = $clog2(CANVAS_WIDTH);
  localparam int YW = $clog2(CANVAS_HEIGHT);
  localparam int FW = $clog2(NUM_FRAMES);
  localparam int AW = $clog2(ANIM_DIV + 1);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, PRESENT = 2'd2, GAP = 2'd3;
  logic          act [MAX_SPRITES];
  logic [XW-1:0] ex  [MAX_SPRITES];
  logic [YW-1:0] ey  [MAX_SPRITES];
  logic [FW-1:0] eb  [MAX_SPRITES];
  logic [2:0]    el  [MAX_SPRITES];
  logic [2:0]    ph  [MAX_SPRITES];
  logic [5:0]    prev_frame_count;
  logic [AW-1:0] anim_cnt;
  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          restart;
  logic          tick, advance, restart_d, last;
  logic [2:0]    wr_len;
  logic [FW:0]   fsum;
  logic [FW-1:0] cur_frame;
  always_comb begin
    tick      = frame_count != prev_frame_count;
    advance   = tick && anim_cnt == AW'(ANIM_DIV - 1);
    restart_d = restart || (tick && state != IDLE);
    last      = idx == IW'(MAX_SPRITES - 1);
    wr_len    = wr_anim_len == 3'd0 ? 3'd1 : wr_anim_len > 3'(MAX_ANIM) ? 3'(MAX_ANIM) : wr_anim_len;
    fsum      = {1'b0, eb[idx]} + (FW + 1)'(ph[idx]);
    cur_frame = fsum > (FW + 1)'(NUM_FRAMES - 1) ? FW'(NUM_FRAMES - 1) : fsum[FW-1:0];
  end
  assign sprite_valid = state == PRESENT;
  assign scan_busy    = state != IDLE;
  // A write to an entry always beats a simultaneous phase advance.
  always_ff @(posedge clk_pixel)
    for (int i = 0; i < MAX_SPRITES; i++)
      if (sys_rst) begin
        act[i] <= 1'b0;
        ph[i]  <= 3'd0;
      end else if (wr_en && wr_index == IW'(i)) begin
        act[i] <= wr_active;
        ex[i]  <= wr_x;
        ey[i]  <= wr_y;
        eb[i]  <= wr_frame_base;
        el[i]  <= wr_len;
        ph[i]  <= 3'd0;
      end else if (advance)
        ph[i] <= ph[i] >= el[i] - 3'd1 ? 3'd0 : ph[i] + 3'd1;
  always_ff @(posedge clk_pixel)
    if (sys_rst) begin
      prev_frame_count <= 6'd0;
      anim_cnt         <= '0;
    end else begin
      prev_frame_count <= frame_count;
      if (tick) anim_cnt <= advance ? '0 : anim_cnt + AW'(1);
    end
  // An overrun never withdraws a live offer; it rewinds idx at the next FETCH or GAP.
  always_ff @(posedge clk_pixel)
    if (sys_rst) begin
      state               <= IDLE;
      idx                 <= '0;
      restart             <= 1'b0;
      frame_overrun       <= 1'b0;
      sprite_x            <= '0;
      sprite_y            <= '0;
      sprite_frame_number <= '0;
    end else begin
      frame_overrun <= tick && state != IDLE;
      restart       <= state == PRESENT && restart_d;
      case (state)
        IDLE: if (tick) begin
          idx   <= '0;
          state <= FETCH;
        end
        FETCH:
          if (restart_d) idx <= '0;
          else if (act[idx]) begin
            sprite_x            <= ex[idx];
            sprite_y            <= ey[idx];
            sprite_frame_number <= cur_frame;
            state               <= PRESENT;
          end else if (last) state <= IDLE;
          else idx <= idx + IW'(1);
        PRESENT: if (sprite_ready) state <= GAP;
        default:
          if (restart_d) begin
            idx   <= '0;
            state <= FETCH;
          end else if (last) state <= IDLE;
          else begin
            idx   <= idx + IW'(1);
            state <= FETCH;
          end
      endcase
    end
endmodule

// File: tb/tb_sprite_scheduler.sv
// tb_sprite_scheduler: scoreboard bench; a table model predicts each offer and the monitor checks it on transfer.
module tb_sprite_scheduler;
  logic       clk = 0;
  logic       sys_rst = 1;
  logic [5:0] frame_count = 0;
  logic       wr_en = 0;
  logic [3:0] wr_index = 0;
  logic       wr_active = 0;
  logic [8:0] wr_x = 0;
  logic [9:0] wr_y = 0;
  logic [4:0] wr_frame_base = 0;
  logic [2:0] wr_anim_len = 0;
  logic       sprite_ready = 1;
  logic       sprite_valid, scan_busy, frame_overrun;
  logic [8:0] sprite_x;
  logic [9:0] sprite_y;
  logic [4:0] sprite_frame_number;
  int checks = 0, failures = 0;
  int xfers = 0, valid_cycles = 0, overruns = 0;
  logic [23:0] exp_q[$];
  logic        m_act [16];
  int          m_x [16], m_y [16], m_base [16], m_len [16], m_ph [16];
  int          m_anim = 0;

  sprite_scheduler dut (
    .clk_pixel(clk), .sys_rst(sys_rst), .frame_count(frame_count),
    .wr_en(wr_en), .wr_index(wr_index), .wr_active(wr_active), .wr_x(wr_x), .wr_y(wr_y),
    .wr_frame_base(wr_frame_base), .wr_anim_len(wr_anim_len), .sprite_ready(sprite_ready),
    .sprite_valid(sprite_valid), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_frame_number(sprite_frame_number), .scan_busy(scan_busy), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!sys_rst) begin
    if (frame_overrun) overruns++;
    if (sprite_valid) valid_cycles++;
    if (sprite_valid && sprite_ready) begin
      xfers++;
      if (exp_q.size() == 0) chk("extra_offer", 1, 0);
      else chk("offer", {sprite_x, sprite_y, sprite_frame_number}, exp_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int i, input logic a, input int x, input int y, input int b, input int l);
    wr_en = 1; wr_index = 4'(i); wr_active = a; wr_x = 9'(x); wr_y = 10'(y);
    wr_frame_base = 5'(b); wr_anim_len = 3'(l);
    cyc();
    wr_en = 0;
    m_act[i] = a; m_x[i] = x; m_y[i] = y; m_base[i] = b; m_ph[i] = 0;
    m_len[i] = l == 0 ? 1 : l > 4 ? 4 : l;
  endtask

  task automatic model_tick();
    if (m_anim == 3) begin
      m_anim = 0;
      for (int i = 0; i < 16; i++) m_ph[i] = m_ph[i] >= m_len[i] - 1 ? 0 : m_ph[i] + 1;
    end else m_anim++;
    for (int i = 0; i < 16; i++)
      if (m_act[i]) begin
        int f;
        f = m_base[i] + m_ph[i] > 17 ? 17 : m_base[i] + m_ph[i];
        exp_q.push_back({9'(m_x[i]), 10'(m_y[i]), 5'(f)});
      end
  endtask

  task automatic do_tick();
    model_tick();
    frame_count = frame_count + 6'd1;
  endtask

  task automatic wait_idle();
    int n = 0;
    cyc(); cyc();
    while (scan_busy && n < 2000) begin cyc(); n++; end
    chk("idle_reached", int'(scan_busy), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!sprite_valid && n < 200) begin cyc(); n++; end
    chk("valid_reached", int'(sprite_valid), 1);
  endtask

  task automatic clear_table();
    for (int i = 0; i < 16; i++) wr(i, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int lat, base, ov0, vc0;
    for (int i = 0; i < 16; i++) begin m_act[i] = 0; m_ph[i] = 0; m_len[i] = 1; end
    repeat (3) cyc();
    chk("rst_valid", int'(sprite_valid), 0);
    chk("rst_xyf", {sprite_x, sprite_y, sprite_frame_number}, 0);
    chk("rst_busy", int'(scan_busy), 0);
    chk("rst_overrun", int'(frame_overrun), 0);
    sys_rst = 0;
    cyc();
    // entries 0, 3, 15 with ready held high
    wr(0, 1, 11, 21, 2, 1);
    wr(3, 1, 33, 333, 7, 2);
    wr(15, 1, 359, 719, 17, 1);
    cyc();
    valid_cycles = 0; xfers = 0;
    do_tick();
    lat = 0;
    do begin @(posedge clk); @(negedge clk); lat++; end while (!sprite_valid && lat < 50);
    chk("first_latency", lat, 2);
    cyc();
    wait_idle();
    chk("t1_xfers", xfers, 3);
    chk("t1_valid_cycles", valid_cycles, 3);
    chk("t1_queue_empty", exp_q.size(), 0);
    // stalled offer with a write to the presented entry
    sprite_ready = 0; xfers = 0;
    do_tick();
    wait_valid();
    repeat (25) cyc();
    wr(0, 1, 200, 600, 9, 3);
    repeat (25) cyc();
    chk("hold_valid", int'(sprite_valid), 1);
    chk("hold_data", {sprite_x, sprite_y, sprite_frame_number}, {9'd11, 10'd21, 5'd2});
    chk("hold_no_xfer", xfers, 0);
    sprite_ready = 1;
    wait_idle();
    chk("t2_xfers", xfers, 3);
    chk("t2_queue_empty", exp_q.size(), 0);
    // animation: cycling, len 0 constant, saturation at the last frame
    clear_table();
    wr(0, 1, 10, 20, 4, 3);
    wr(1, 1, 30, 40, 4, 0);
    wr(2, 1, 50, 60, 17, 4);
    repeat (14) begin
      do_tick();
      repeat (100) cyc();
    end
    chk("t3_queue_empty", exp_q.size(), 0);
    // overrun while entry 5 is pending
    clear_table();
    wr(0, 1, 100, 200, 1, 1);
    wr(5, 1, 105, 205, 5, 1);
    base = xfers;
    do_tick();
    lat = 0;
    while (xfers < base + 1 && lat < 200) begin cyc(); lat++; end
    chk("t4_first_xfer", xfers - base, 1);
    sprite_ready = 0;
    wait_valid();
    chk("t4_pending_x", int'(sprite_x), 105);
    ov0 = overruns;
    do_tick();
    repeat (5) cyc();
    sprite_ready = 1;
    wait_idle();
    chk("t4_overrun_once", overruns - ov0, 1);
    chk("t4_xfers", xfers - base, 4);
    chk("t4_queue_empty", exp_q.size(), 0);
    // reset during PRESENT
    sprite_ready = 0;
    do_tick();
    wait_valid();
    sys_rst = 1;
    cyc();
    chk("mid_rst_valid", int'(sprite_valid), 0);
    chk("mid_rst_xyf", {sprite_x, sprite_y, sprite_frame_number}, 0);
    chk("mid_rst_busy", int'(scan_busy), 0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin m_act[i] = 0; m_ph[i] = 0; end
    m_anim = 0;
    sys_rst = 0;
    model_tick();
    sprite_ready = 1;
    vc0 = valid_cycles;
    cyc(); cyc();
    do_tick();
    repeat (40) cyc();
    chk("post_rst_no_offers", valid_cycles - vc0, 0);
    chk("post_rst_idle", int'(scan_busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
